div16: RTL
==========

// Module: div16
// PURPOSE
//  Iterative signed fixed-point divider; the inverse of the twiddle multiplier in the FFT datapath.
//  Computes out = (in_17bit << FRAC) / in_8bit: 17-bit 2's-complement data divided by 8-bit
//  2's-complement Q1.7 coefficient. Used in IFFT de-normalisation and coefficient-undo paths.
//  Non-pipelined: one operation in flight, restoring division at 1 quotient bit per clock.
// PARAMETERS
//  DW_A  17  data (dividend) width, 2's complement
//  DW_B  8   coefficient (divisor) width, 2's complement
//  FRAC  7   fractional bits of divisor; dividend magnitude is left-shifted by FRAC
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  in_valid   in   1   operand valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  in_17bit   in   17  dividend, 2's complement
//  in_8bit    in   8   divisor, 2's complement Q1.7
//  out_valid  out  1   result valid; held until out_ready
//  out_ready  in   1   downstream accepts result
//  out        out  17  quotient, 2's complement, saturated
//  div0       out  1   divisor was zero (valid with out_valid)
//  sat        out  1   result saturated (valid with out_valid)
// BEHAVIOUR
//  Reset: state=IDLE; out=0, out_valid=0, div0=0, sat=0, in_ready=1 after reset; all internal regs 0.
//  Reset mid-operation aborts immediately to IDLE; partial result discarded, never emitted.
//  FSM: IDLE -> LOAD -> DIV (DW_A+FRAC=24 cycles, bit counter 23..0) -> FIX -> DONE -> IDLE.
//   IDLE: in_ready=1; in_valid&in_ready at edge E0 captures operands, goes LOAD.
//   LOAD (E1): magnitudes |a| (17b, so -65536 -> 65536) and |b| (8b, -128 -> 128), sign=a[16]^b[7],
//         dividend = |a|<<7 (24b), remainder=0, div0=(b==0).
//   DIV (E2..E25): restoring step: rem={rem,msb}; if rem>=|b| then rem-=|b|, qbit=1 else qbit=0.
//   FIX (E26): apply sign + saturation, register out/div0/sat, out_valid=1, go DONE.
//   DONE: hold out, div0, sat, out_valid stable; on out_valid&out_ready -> IDLE, out_valid=0 next edge.
//  Latency: out_valid rises at edge E26 (26 clocks after accepting edge); throughput <= 1 per 27 clocks.
//  in_valid outside IDLE is ignored (in_ready=0); operands not re-sampled while busy.
//  No accept on the same edge as the output handshake; in_ready returns the cycle after DONE exits.
//  Saturation: positive magnitude > 65535 -> out=0x0FFFF, sat=1; negative magnitude > 65536 ->
//   out=0x10000, sat=1; else out = sign ? -mag : mag (two's complement, 17b).
//  Divide by zero: restoring loop naturally yields all-ones quotient; constant latency kept;
//   div0=1, sat=1, out = 0x0FFFF if sign of a is 0 (incl. a=0), else 0x10000.
//  out (and flags) change only at the FIX edge; stable throughout DONE regardless of inputs.
// CONFIGURATION
//  DIV_ROUND_EN defined: after DIV, if 2*rem >= |b| then magnitude += 1 (round half away from zero),
//   applied before saturation; still 26-clock latency (done inside FIX). Not applied when div0.
//  DIV_ROUND_EN undefined: quotient truncated toward zero.
// TESTING
//  a=0x00100 (256), b=0x40 (0.5) -> out=0x00200, div0=0, sat=0, out_valid at 26 clocks after accept.
//  a=0x1FF00 (-256), b=0x40 -> out=0x1FE00; a=0x003E8 (1000), b=0xC0 (-0.5) -> out=0x1F830 (-2000).
//  a=0x0FFFF, b=0x01 -> out=0x0FFFF, sat=1; a=0x10000, b=0x80 (-1.0) -> out=0x0FFFF, sat=1.
//  b=0x00, a=0x1FFFB (-5) -> out=0x10000, div0=1, sat=1; b=0x00, a=0 -> out=0x0FFFF, div0=1.
//  a=0x00001, b=0x03 -> out=0x0002A (truncate); with DIV_ROUND_EN -> out=0x0002B.
//  Hold out_ready=0 for 10 clocks: out/flags stable, in_ready=0, new in_valid ignored; then
//   pulse rst_n low during DIV -> outputs 0, in_ready=1, no out_valid for that operation.

Source files
------------

// File: rtl/div16_if.sv
// ----------------------------------------------------------------------------
// div16_if -- operand / result handshake bundle for the div16 divider.
//
// Signals (directions as seen from the divider, i.e. the slave modport):
//   in_valid   in   operand valid
//   in_ready   out  divider can accept operands (high only while idle)
//   in_17bit   in   dividend, 2's complement, DW_A bits
//   in_8bit    in   divisor, 2's complement Q1.(DW_B-1), DW_B bits
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts the result
//   out        out  quotient, 2's complement, saturated, DW_A bits
//   div0       out  divisor was zero (qualified by out_valid)
//   sat        out  result saturated (qualified by out_valid)
//
// master: the upstream/downstream side that drives operands and out_ready.
// slave : the divider itself.
// ----------------------------------------------------------------------------
interface div16_if #(
  parameter int DW_A = 17,
  parameter int DW_B = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [DW_A-1:0] in_17bit;
  logic [DW_B-1:0] in_8bit;
  logic            out_valid;
  logic            out_ready;
  logic [DW_A-1:0] out;
  logic            div0;
  logic            sat;

  modport master (
    output in_valid, in_17bit, in_8bit, out_ready,
    input  in_ready, out_valid, out, div0, sat
  );

  modport slave (
    input  in_valid, in_17bit, in_8bit, out_ready,
    output in_ready, out_valid, out, div0, sat
  );
endinterface

// File: rtl/div16.sv
// ----------------------------------------------------------------------------
// div16 -- iterative signed fixed-point divider.
//
// Computes out = (a << FRAC) / b, where a is a DW_A-bit 2's-complement
// dividend and b a DW_B-bit 2's-complement Q1.FRAC coefficient. It undoes the
// twiddle multiply in the FFT datapath. Restoring division on magnitudes,
// one quotient bit per clock, one operation in flight.
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous reset, active low (aborts any operation in flight)
//   bus    div16_if.slave: in_valid/in_ready/in_17bit/in_8bit operand
//          handshake, out_valid/out_ready/out/div0/sat result handshake
//
// Timing: operands accepted at edge E0 (in_ready high only in IDLE), result
// registered at E26, held stable until out_valid & out_ready.
//
// Optional feature (macro DIV_ROUND_EN): round the magnitude half away from
// zero before saturation. Without it the quotient truncates toward zero.
// ----------------------------------------------------------------------------
module div16 #(
  parameter int DW_A = 17,
  parameter int DW_B = 8,
  parameter int FRAC = 7
) (
  input logic   clk,
  input logic   rst_n,
  div16_if.slave bus
);

  localparam int QW = DW_A + FRAC;   // quotient / shifted dividend width
  localparam int CW = $clog2(QW);    // bit counter width

  localparam logic [DW_A-1:0] POS_MAX = {1'b0, {(DW_A-1){1'b1}}};
  localparam logic [DW_A-1:0] NEG_MIN = {1'b1, {(DW_A-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_TOP = CW'(QW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [DW_A-1:0] a_q;
  logic [DW_B-1:0] b_q;
  logic [DW_B-1:0] mag_b_q;   // |b| as unsigned; -2^(DW_B-1) maps to 2^(DW_B-1)
  logic            sign_q;
  logic            zero_q;
  // Shift register: dividend bits leave at the top, quotient bits enter at the bottom.
  logic [QW-1:0]   dvd_q;
  // Remainder is always < |b| <= 2^(DW_B-1), so DW_B bits are enough.
  logic [DW_B-1:0] rem_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [DW_A-1:0] out_q;
  logic            div0_q;
  logic            sat_q;

  // ---------------- LOAD: operand magnitudes ----------------
  logic [DW_A-1:0] mag_a_d;
  logic [DW_B-1:0] mag_b_d;

  always_comb begin
    mag_a_d = a_q[DW_A-1] ? (~a_q + 1'b1) : a_q;
    mag_b_d = b_q[DW_B-1] ? (~b_q + 1'b1) : b_q;
  end

  // ---------------- DIV: one restoring step ----------------
  logic [DW_B:0]   rem_sh_d;
  logic [DW_B:0]   rem_sub_d;
  logic            qbit_d;
  logic [DW_B-1:0] rem_d;

  always_comb begin
    rem_sh_d  = {rem_q, dvd_q[QW-1]};
    rem_sub_d = rem_sh_d - {1'b0, mag_b_q};
    qbit_d    = (rem_sh_d >= {1'b0, mag_b_q});
    // With |b| = 0 every step subtracts nothing and yields a 1 quotient bit.
    rem_d     = qbit_d ? rem_sub_d[DW_B-1:0] : rem_sh_d[DW_B-1:0];
  end

  // ---------------- FIX: rounding, sign and saturation ----------------
  logic [QW:0]     mag_d;
  logic [DW_A-1:0] out_d;
  logic            sat_d;

  always_comb begin
    mag_d = {1'b0, dvd_q};
`ifdef DIV_ROUND_EN
    if (!zero_q && ({rem_q, 1'b0} >= {1'b0, mag_b_q})) begin
      mag_d = mag_d + 1'b1;
    end
`endif
    out_d = '0;
    sat_d = 1'b0;
    if (zero_q) begin
      // Division by zero saturates toward the sign of the dividend alone.
      out_d = a_q[DW_A-1] ? NEG_MIN : POS_MAX;
      sat_d = 1'b1;
    end else if (!sign_q && (mag_d > (QW+1)'(POS_MAX))) begin
      out_d = POS_MAX;
      sat_d = 1'b1;
    end else if (sign_q && (mag_d > (QW+1)'(NEG_MIN))) begin
      out_d = NEG_MIN;
      sat_d = 1'b1;
    end else begin
      out_d = sign_q ? (~mag_d[DW_A-1:0] + 1'b1) : mag_d[DW_A-1:0];
    end
  end

  // ---------------- control FSM with registered outputs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mag_b_q     <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      dvd_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      div0_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.in_17bit;
            b_q        <= bus.in_8bit;
            in_ready_q <= 1'b0;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          mag_b_q <= mag_b_d;
          sign_q  <= a_q[DW_A-1] ^ b_q[DW_B-1];
          zero_q  <= (b_q == '0);
          dvd_q   <= {mag_a_d, {FRAC{1'b0}}};
          rem_q   <= '0;
          cnt_q   <= CNT_TOP;
          state_q <= S_DIV;
        end
        S_DIV: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[QW-2:0], qbit_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          out_q       <= out_d;
          sat_q       <= sat_d;
          div0_q      <= zero_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          // in_ready rises together with the IDLE entry, so no accept can
          // coincide with the output handshake edge.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.div0      = div0_q;
  assign bus.sat       = sat_q;

endmodule
